// File: rtl/alsu_driver.sv
`default_nettype none
// ============================================================================
// Module   : alsu_driver
// Purpose  : Queues ALSU commands in a small FIFO and sequences each one onto
//            a pipelined ALSU: optional operand preload for shift/rotate,
//            multi-cycle issue, fixed-latency wait, then result handshake.
// Revision : 1.0 - initial release
// ============================================================================
module alsu_driver #(
  parameter int FIFO_DEPTH   = 4,
  parameter int ALSU_LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [2:0]                    cmd_opcode,
  input  logic [2:0]                    cmd_a,
  input  logic [2:0]                    cmd_b,
  input  logic [6:0]                    cmd_flags,
  input  logic [2:0]                    cmd_count,
  output logic [2:0]                    alsu_A,
  output logic [2:0]                    alsu_B,
  output logic [2:0]                    alsu_opcode,
  output logic [6:0]                    alsu_flags,
  input  logic [5:0]                    alsu_out,
  input  logic [15:0]                   alsu_leds,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [5:0]                    res_out,
  output logic [15:0]                   res_leds,
  output logic                          res_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] c_full_count = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0]  c_wait_init  = 8'(ALSU_LATENCY - 1);
  // Preload drive: opcode 0 with bypass_A so the ALSU output register takes A.
  localparam logic [6:0]  c_load_flags = 7'b0100000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  // FIFO entry packing: {opcode, a, b, flags, count}
  logic [18:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_cnt;
  logic [7:0]    w_cnt_nxt;

  // Command in flight, latched at pop
  logic [2:0]    r_op;
  logic [2:0]    r_a;
  logic [2:0]    r_b;
  logic [6:0]    r_flags;
  logic [2:0]    r_steps;

  logic [2:0]    r_alsu_a, r_alsu_b, r_alsu_op;
  logic [6:0]    r_alsu_flags;
  logic [2:0]    w_alsu_a_nxt, w_alsu_b_nxt, w_alsu_op_nxt;
  logic [6:0]    w_alsu_flags_nxt;

  logic          r_res_valid;
  logic [5:0]    r_res_out;
  logic [15:0]   r_res_leds;
  logic          r_res_err;

  logic          w_push;
  logic          w_pop;
  logic          w_capture;
  logic          w_release;
  logic [18:0]   w_head;
  logic [2:0]    w_head_op, w_head_a, w_head_b, w_head_count;
  logic [6:0]    w_head_flags;
  logic          w_head_shift;
  logic          w_cmd_shift;
  logic [6:0]    w_issue_flags;

  assign cmd_ready    = (r_count != c_full_count);
  assign w_push       = cmd_valid && cmd_ready;
  assign w_pop        = (r_state == IDLE) && (r_count != '0);

  assign w_head       = r_mem[r_rd_ptr];
  assign w_head_op    = w_head[18:16];
  assign w_head_a     = w_head[15:13];
  assign w_head_b     = w_head[12:10];
  assign w_head_flags = w_head[9:3];
  assign w_head_count = w_head[2:0];
  assign w_head_shift = (w_head_op == 3'd4) || (w_head_op == 3'd5);

  // Shift/rotate issue must not bypass, otherwise the ALSU never shifts.
  assign w_cmd_shift   = (r_op == 3'd4) || (r_op == 3'd5);
  assign w_issue_flags = w_cmd_shift ? {2'b00, r_flags[4:0]} : r_flags;

  // FIFO storage write (contents need no reset; occupancy gates reads)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_opcode, cmd_a, cmd_b, cmd_flags, cmd_count};
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keeps the count
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Latch the popped command so later pushes cannot disturb it
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_flags <= '0;
      r_steps <= '0;
    end else if (w_pop) begin
      r_op    <= w_head_op;
      r_a     <= w_head_a;
      r_b     <= w_head_b;
      r_flags <= w_head_flags;
      r_steps <= w_head_shift ? w_head_count : 3'd0;
    end
  end

  // State and cycle counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, counter and next ALSU drive; idle drive unless overridden
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_alsu_op_nxt    = 3'd0;
    w_alsu_a_nxt     = 3'd0;
    w_alsu_b_nxt     = 3'd0;
    w_alsu_flags_nxt = 7'd0;
    w_capture        = 1'b0;
    w_release        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pop) begin
          w_cnt_nxt = 8'd0;
          if (w_head_shift) begin
            w_state_nxt      = LOAD;
            w_alsu_a_nxt     = w_head_a;
            w_alsu_flags_nxt = c_load_flags;
          end else begin
            w_state_nxt      = ISSUE;
            w_alsu_op_nxt    = w_head_op;
            w_alsu_a_nxt     = w_head_a;
            w_alsu_b_nxt     = w_head_b;
            w_alsu_flags_nxt = w_head_flags;
          end
        end
      end
      LOAD: begin
        w_state_nxt      = ISSUE;
        w_cnt_nxt        = {5'd0, r_steps};
        w_alsu_op_nxt    = r_op;
        w_alsu_a_nxt     = r_a;
        w_alsu_b_nxt     = r_b;
        w_alsu_flags_nxt = w_issue_flags;
      end
      ISSUE: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = c_wait_init;
        end else begin
          w_cnt_nxt        = r_cnt - 8'd1;
          w_alsu_op_nxt    = r_op;
          w_alsu_a_nxt     = r_a;
          w_alsu_b_nxt     = r_b;
          w_alsu_flags_nxt = w_issue_flags;
        end
      end
      WAIT: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = RESP;
          w_capture   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      RESP: begin
        if (res_ready) begin
          w_state_nxt = IDLE;
          w_release   = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Registered drive toward the ALSU
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_alsu_op    <= '0;
      r_alsu_a     <= '0;
      r_alsu_b     <= '0;
      r_alsu_flags <= '0;
    end else begin
      r_alsu_op    <= w_alsu_op_nxt;
      r_alsu_a     <= w_alsu_a_nxt;
      r_alsu_b     <= w_alsu_b_nxt;
      r_alsu_flags <= w_alsu_flags_nxt;
    end
  end

  // Result capture at the end of WAIT, held until the consumer takes it
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_res_valid <= 1'b0;
      r_res_out   <= '0;
      r_res_leds  <= '0;
      r_res_err   <= 1'b0;
    end else if (w_capture) begin
      r_res_valid <= 1'b1;
      r_res_out   <= alsu_out;
      r_res_leds  <= alsu_leds;
      r_res_err   <= (alsu_leds != 16'd0);
    end else if (w_release) begin
      r_res_valid <= 1'b0;
    end
  end

  assign alsu_opcode = r_alsu_op;
  assign alsu_A      = r_alsu_a;
  assign alsu_B      = r_alsu_b;
  assign alsu_flags  = r_alsu_flags;
  assign res_valid   = r_res_valid;
  assign res_out     = r_res_out;
  assign res_leds    = r_res_leds;
  assign res_err     = r_res_err;
  assign fifo_count  = r_count;
  assign busy        = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alsu_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_alsu_driver
// Purpose  : Directed self-checking bench for alsu_driver with a behavioural
//            two-stage ALSU (A priority, full adder on) closing the loop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alsu_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_opcode, cmd_a, cmd_b, cmd_count;
  logic [6:0]  cmd_flags;
  logic [2:0]  alsu_A, alsu_B, alsu_opcode;
  logic [6:0]  alsu_flags;
  logic [5:0]  alsu_out;
  logic [15:0] alsu_leds;
  logic        res_valid, res_ready, res_err;
  logic [5:0]  res_out;
  logic [15:0] res_leds;
  logic [2:0]  fifo_count;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [2:0] snap1_op, snap1_a, snap2_op, snap2_a;
  logic [6:0] snap1_fl, snap2_fl;

  alsu_driver #(.FIFO_DEPTH(4), .ALSU_LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_flags(cmd_flags), .cmd_count(cmd_count),
    .alsu_A(alsu_A), .alsu_B(alsu_B), .alsu_opcode(alsu_opcode),
    .alsu_flags(alsu_flags),
    .alsu_out(alsu_out), .alsu_leds(alsu_leds),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_out(res_out), .res_leds(res_leds), .res_err(res_err),
    .fifo_count(fifo_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALSU: input register stage then output register stage
  logic [2:0]  m_a = '0, m_b = '0, m_op = '0;
  logic [6:0]  m_fl = '0;
  logic [5:0]  m_out = '0;
  logic [15:0] m_leds = '0;
  logic        m_inv;
  assign m_inv = (m_op == 3'd6) || (m_op == 3'd7) || ((m_fl[3] || m_fl[4]) && (m_op > 3'd1));
  assign alsu_out  = m_out;
  assign alsu_leds = m_leds;

  always @(posedge clk) begin
    m_a  <= alsu_A;
    m_b  <= alsu_B;
    m_op <= alsu_opcode;
    m_fl <= alsu_flags;
    m_leds <= m_inv ? ~m_leds : 16'd0;
    if (m_inv)           m_out <= 6'd0;
    else if (m_fl[5])    m_out <= {3'd0, m_a};
    else if (m_fl[6])    m_out <= {3'd0, m_b};
    else begin
      case (m_op)
        3'd0: m_out <= {3'd0, m_a & m_b};
        3'd1: m_out <= {3'd0, m_a ^ m_b};
        3'd2: m_out <= {3'd0, m_a} + {3'd0, m_b} + {5'd0, m_fl[0]};
        3'd3: m_out <= 6'(m_a) * 6'(m_b);
        3'd4: m_out <= m_fl[2] ? {m_fl[1], m_out[5:1]} : {m_out[4:0], m_fl[1]};
        default: m_out <= m_fl[2] ? {m_out[0], m_out[5:1]} : {m_out[4:0], m_out[5]};
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_cmd(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                           input logic [6:0] fl, input logic [2:0] cnt);
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    cmd_flags  = fl;
    cmd_count  = cnt;
  endtask

  // Push one command into an idle driver, time it, check and release the result
  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [2:0] a,
                         input logic [2:0] b, input logic [6:0] fl, input logic [2:0] cnt,
                         input logic [5:0] exp_out, input logic exp_err,
                         input logic [15:0] exp_leds, input int exp_lat);
    int k;
    bit seen;
    drive_cmd(op, a, b, fl, cnt);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 0;
    seen = 0;
    while (!seen && k < 60) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (k == 1) begin snap1_op = alsu_opcode; snap1_a = alsu_A; snap1_fl = alsu_flags; end
      if (k == 2) begin snap2_op = alsu_opcode; snap2_a = alsu_A; snap2_fl = alsu_flags; end
      if (res_valid) seen = 1;
    end
    chk({tag, "_latency"}, k, exp_lat + 1);
    chk({tag, "_out"}, res_out, exp_out);
    chk({tag, "_err"}, res_err, exp_err);
    chk({tag, "_leds"}, res_leds, exp_leds);
    repeat (2) @(negedge clk);
    chk({tag, "_hold_valid"}, res_valid, 1);
    chk({tag, "_hold_out"}, res_out, exp_out);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_release_valid"}, res_valid, 0);
    chk({tag, "_release_busy"}, busy, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    int n;
    int k;
    logic [2:0] cnt_after2;
    logic [5:0] got [5];

    rst = 1'b0; res_ready = 1'b0;
    cmd_valid = 1'b0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0; cmd_flags = '0; cmd_count = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Reset state
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_out", res_out, 0);
    chk("rst_res_leds", res_leds, 0);
    chk("rst_res_err", res_err, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alsu_drive", {alsu_opcode, alsu_A, alsu_B, alsu_flags}, 0);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);

    // Add 5+7+cin: drive verbatim at pop, idle drive once waiting
    run_cmd("add", 3'd2, 3'd5, 3'd7, 7'b0000001, 3'd0, 6'd13, 1'b0, 16'd0, 3);
    chk("add_issue_drive", {snap1_op, snap1_a, snap1_fl}, {3'd2, 3'd5, 7'b0000001});
    chk("add_wait_idle_drive", {snap2_op, snap2_a, snap2_fl}, 0);

    // Multiply 7*7
    run_cmd("mul", 3'd3, 3'd7, 3'd7, 7'b0000000, 3'd0, 6'd49, 1'b0, 16'd0, 3);

    // Shift left with serial_in=1, two extra steps; bypass_B in command is cleared on issue
    run_cmd("shift", 3'd4, 3'd5, 3'd0, 7'b1000010, 3'd2, 6'd47, 1'b0, 16'd0, 6);
    chk("shift_load_drive", {snap1_op, snap1_a, snap1_fl}, {3'd0, 3'd5, 7'b0100000});
    chk("shift_issue_drive", {snap2_op, snap2_a, snap2_fl}, {3'd4, 3'd5, 7'b0000010});

    // Invalid opcode
    run_cmd("invalid", 3'd6, 3'd3, 3'd2, 7'b0000000, 3'd0, 6'd0, 1'b1, 16'hFFFF, 3);

    // Backpressure: seven back-to-back pushes, results held
    acc = 0;
    cnt_after2 = '0;
    for (int i = 1; i <= 7; i++) begin
      drive_cmd(3'd2, i[2:0], 3'd0, 7'd0, 3'd0);
      if (cmd_ready) acc++;
      @(posedge clk);
      @(negedge clk);
      if (i == 2) cnt_after2 = fifo_count;
    end
    cmd_valid = 1'b0;
    chk("bp_push_pop_count", cnt_after2, 1);
    chk("bp_accepted", acc, 5);
    chk("bp_cmd_ready", cmd_ready, 0);
    chk("bp_fifo_count", fifo_count, 4);

    res_ready = 1'b1;
    n = 0;
    k = 0;
    while (n < 5 && k < 200) begin
      if (res_valid) begin
        got[n] = res_out;
        n++;
      end
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    res_ready = 1'b0;
    chk("bp_drained", n, 5);
    for (int j = 0; j < 5; j++) chk("bp_order", (j < n) ? got[j] : 6'h3F, j + 1);
    chk("bp_empty", fifo_count, 0);
    chk("bp_idle", busy, 0);

    // Reset while issuing a long shift with two commands queued behind it
    drive_cmd(3'd4, 3'd1, 3'd0, 7'd0, 3'd7);
    @(posedge clk); @(negedge clk);
    drive_cmd(3'd2, 3'd1, 3'd1, 7'd0, 3'd0);
    @(posedge clk); @(negedge clk);
    drive_cmd(3'd2, 3'd2, 3'd2, 7'd0, 3'd0);
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    chk("midrst_busy_before", busy, 1);
    chk("midrst_issue_op", alsu_opcode, 4);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_fifo_count", fifo_count, 0);
    chk("midrst_alsu_drive", {alsu_opcode, alsu_A, alsu_B, alsu_flags}, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    repeat (20) @(negedge clk);
    chk("midrst_no_result", res_valid, 0);
    chk("midrst_still_idle", busy, 0);

    // Recovery after reset
    run_cmd("recover", 3'd2, 3'd1, 3'd2, 7'b0000000, 3'd0, 6'd3, 1'b0, 16'd0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alsu_driver.md
ALSU_DRIVER -- requirements
Module: alsu_driver

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, giving command FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter ALSU_LATENCY, default 2, giving ALSU port-to-out register stages.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command accepted when high with cmd_valid; equals !fifo_full.
REQ-007 cmd_opcode  input  3  ALSU opcode.
REQ-008 cmd_a, cmd_b  input  3 each  operands.
REQ-009 cmd_flags  input  7  {bypass_B, bypass_A, red_op_B, red_op_A, direction, serial_in, cin}, bit 6 down to bit 0.
REQ-010 cmd_count  input  3  extra shift/rotate steps; ignored for opcodes other than 4 and 5.
REQ-011 alsu_A, alsu_B, alsu_opcode  output  3 each  registered drive to ALSU.
REQ-012 alsu_flags  output  7  registered drive to ALSU control inputs, same packing as cmd_flags.
REQ-013 alsu_out  input  6; alsu_leds  input  16  ALSU results.
REQ-014 res_valid  output  1; res_ready  input  1  result handshake.
REQ-015 res_out  output  6; res_leds  output  16; res_err  output  1  captured result, held while res_valid.
REQ-016 fifo_count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy; busy  output  1  state != IDLE.

Function
REQ-017 Push on cmd_valid && cmd_ready; pop only in IDLE when FIFO non-empty; simultaneous push and pop SHALL leave fifo_count unchanged; push while full is impossible since cmd_ready=0, even if a pop occurs the same cycle.
REQ-018 FSM states SHALL be IDLE, LOAD, ISSUE, WAIT, RESP.
REQ-019 Idle drive SHALL be alsu_opcode=0, alsu_A=alsu_B=0, alsu_flags=0; it is driven in IDLE, WAIT and RESP.
REQ-020 IDLE pop edge: opcode 4/5 -> LOAD, drive opcode=0, A=cmd_a, B=0, flags=7'b0100000 (bypass_A only); otherwise -> ISSUE, drive the command verbatim.
REQ-021 LOAD SHALL last exactly 1 cycle, then ISSUE.
REQ-022 ISSUE SHALL hold the command drive for N cycles: N=cmd_count+1 for opcodes 4/5, with bypass_A/B forced 0; N=1 otherwise.
REQ-023 WAIT SHALL last ALSU_LATENCY cycles; on the leaving edge res_out<=alsu_out, res_leds<=alsu_leds, res_err<=(alsu_leds!=0), res_valid<=1, state->RESP.
REQ-024 Latency from pop edge to res_valid high SHALL be N+ALSU_LATENCY cycles, plus 1 for opcodes 4/5.
REQ-025 RESP SHALL hold res_* stable until res_ready=1, then res_valid<=0 and state->IDLE; one dead cycle between commands.
REQ-026 Opcodes 6/7 SHALL be issued unchanged; the resulting leds!=0 sets res_err.
REQ-027 Command fields SHALL be latched at pop; FIFO pushes during execution do not alter the command in flight.

Reset
REQ-028 rst=0 at a posedge SHALL force state=IDLE, FIFO empty (fifo_count=0), res_valid=0, res_out=0, res_leds=0, res_err=0, idle drive on alsu_*, busy=0; cmd_ready=1 from the following cycle.
REQ-029 Reset mid-operation SHALL abandon the command in flight and all queued commands without producing a result.

Verification (ALSU in loop, INPUT_PRIORITY="A", FULL_ADDER="ON")
REQ-030 Add: opcode=2, a=5, b=7, cin=1 -> res_out=13, res_err=0, res_valid 3 cycles after pop.
REQ-031 Multiply: opcode=3, a=7, b=7 -> res_out=49, res_err=0.
REQ-032 Shift: opcode=4, a=5, direction=0, serial_in=1, count=2 -> res_out=6'b101111 (47), res_valid 6 cycles after pop.
REQ-033 Invalid: opcode=6 -> res_out=0, res_err=1, res_leds!=0.
REQ-034 Backpressure: res_ready=0, push 7 back-to-back -> exactly 5 accepted, cmd_ready=0, fifo_count=4; releasing res_ready drains all 5 in order.
REQ-035 Reset in ISSUE: rst=0 for 1 cycle -> next cycle res_valid=0, fifo_count=0, alsu_* at idle drive, busy=0.
